// File: rtl/tm_snn_pkg.sv
// Shared types and helpers for the time-multiplexed SNN blocks.
// sat_add serves both the unsigned build and the signed build (TM_SYN_INHIBIT_EN).
package tm_snn_pkg;

   localparam int unsigned N_CH_DEF = 8;
   localparam int unsigned W_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      EMIT  = 2'd2
   } state_e;

   // Clamp base+delta into [0, 2^w-1]; delta is never negative in the unsigned build
   function automatic int sat_add(input int base, input int delta, input int unsigned w);
      int sum;
      int hi;
      sum = base + delta;
      hi  = (1 << w) - 1;
      if (sum < 0) begin
         return 0;
      end else if (sum > hi) begin
         return hi;
      end else begin
         return sum;
      end
   endfunction

endpackage

// File: rtl/tm_syn_acc_update.sv
// Next-value computation for one synaptic accumulator: leak, weight add, saturate.
// With TM_SYN_INHIBIT_EN defined the weight is signed and the result also floors at 0.
module tm_syn_acc_update
   import tm_snn_pkg::*;
#(
   parameter int unsigned W           = W_DEF,
   parameter int unsigned DECAY_SHIFT = 1
) (
   input  logic [W-1:0] acc_i,
   input  logic [W-1:0] weight_i,
   input  logic         spike_i,
   output logic [W-1:0] acc_next_o
);

   logic [W-1:0] leak;
   logic [W-1:0] base;
   int           delta;

   always_comb begin
      leak  = acc_i >> DECAY_SHIFT;
      base  = acc_i - leak;
      delta = 0;
      if (spike_i) begin
`ifdef TM_SYN_INHIBIT_EN
         delta = int'($signed(weight_i));
`else
         delta = int'(weight_i);
`endif
      end
      acc_next_o = W'(sat_add(int'(base), delta, W));
   end

endmodule

// File: rtl/tm_syn_decoder.sv
// Time-multiplexed synaptic decoder: spike frame in, per-channel decaying current out.
// Optional signed/inhibitory weights via TM_SYN_INHIBIT_EN.
module tm_syn_decoder
   import tm_snn_pkg::*;
#(
   parameter int unsigned N_CH        = N_CH_DEF,
   parameter int unsigned W           = W_DEF,
   parameter int unsigned DECAY_SHIFT = 1,
   parameter int          W_RST       = 32,
   localparam int unsigned CW         = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] spike_in,
   input  logic            spike_valid,
   output logic            spike_ready,
   input  logic            wr_en,
   input  logic [CW-1:0]   wr_addr,
   input  logic [W-1:0]    wr_data,
   output logic [W-1:0]    cur_out,
   output logic [CW-1:0]   cur_ch,
   output logic            cur_valid,
   input  logic            cur_ready
);

   localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

   state_e          state_q;
   logic [CW-1:0]   ch_q;
   logic [CW-1:0]   ch_inc;
   logic [N_CH-1:0] frame_q;
   logic [W-1:0]    acc_q [N_CH];
   logic [W-1:0]    w_q   [N_CH];
   logic [W-1:0]    acc_d;
   logic            spike_ready_q;
   logic            cur_valid_q;
   logic [W-1:0]    cur_out_q;
   logic [CW-1:0]   cur_ch_q;

   assign ch_inc      = ch_q + CW'(1);
   assign spike_ready = spike_ready_q;
   assign cur_valid   = cur_valid_q;
   assign cur_out     = cur_out_q;
   assign cur_ch      = cur_ch_q;

   tm_syn_acc_update #(
      .W           (W),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_acc_update (
      .acc_i      (acc_q[ch_q]),
      .weight_i   (w_q[ch_q]),
      .spike_i    (frame_q[ch_q]),
      .acc_next_o (acc_d)
   );

   // Weight RAM, accumulators and the IDLE/SWEEP/EMIT sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ch_q          <= '0;
         frame_q       <= '0;
         spike_ready_q <= 1'b0;
         cur_valid_q   <= 1'b0;
         cur_out_q     <= '0;
         cur_ch_q      <= '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            acc_q[i] <= '0;
            w_q[i]   <= W'(W_RST);
         end
      end else begin
         // Sweep reads w_q before this write lands, so a same-index write takes effect next frame
         if (wr_en) begin
            w_q[wr_addr] <= wr_data;
         end
         case (state_q)
            IDLE: begin
               spike_ready_q <= 1'b1;
               if (spike_valid && spike_ready_q) begin
                  frame_q       <= spike_in;
                  ch_q          <= '0;
                  spike_ready_q <= 1'b0;
                  state_q       <= SWEEP;
               end
            end
            SWEEP: begin
               acc_q[ch_q] <= acc_d;
               if (ch_q == LAST_CH) begin
                  ch_q        <= '0;
                  state_q     <= EMIT;
                  cur_valid_q <= 1'b1;
                  cur_out_q   <= acc_q[0];
                  cur_ch_q    <= '0;
               end else begin
                  ch_q <= ch_inc;
               end
            end
            EMIT: begin
               if (cur_ready) begin
                  if (ch_q == LAST_CH) begin
                     ch_q          <= '0;
                     state_q       <= IDLE;
                     cur_valid_q   <= 1'b0;
                     cur_out_q     <= '0;
                     cur_ch_q      <= '0;
                     spike_ready_q <= 1'b1;
                  end else begin
                     ch_q      <= ch_inc;
                     cur_ch_q  <= ch_inc;
                     cur_out_q <= acc_q[ch_inc];
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tm_syn_decoder.sv
// Directed bench for tm_syn_decoder with hand-computed currents (N_CH=8, W=8, DECAY_SHIFT=1).
// Expectations for the final weight case follow TM_SYN_INHIBIT_EN when it is defined.
module tb_tm_syn_decoder;

   logic       clk;
   logic       rst;
   logic [7:0] spike_in;
   logic       spike_valid;
   logic       spike_ready;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] cur_out;
   logic [2:0] cur_ch;
   logic       cur_valid;
   logic       cur_ready;

   int         errors;
   int         checks;
   int         lat;
   logic [7:0] exp_cur [8];

   tm_syn_decoder #(
      .N_CH        (8),
      .W           (8),
      .DECAY_SHIFT (1),
      .W_RST       (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spike_in    (spike_in),
      .spike_valid (spike_valid),
      .spike_ready (spike_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .cur_out     (cur_out),
      .cur_ch      (cur_ch),
      .cur_valid   (cur_valid),
      .cur_ready   (cur_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 8; i++) exp_cur[i] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic write_w(input logic [2:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   // Returns one cycle after the accepting edge
   task automatic handshake(input logic [7:0] f);
      int n;
      n = 0;
      spike_in    = f;
      spike_valid = 1'b1;
      while (!spike_ready && n < 50) begin
         tick();
         n++;
      end
      chk("handshake_timeout", 32'(n < 50), 32'd1);
      tick();
      spike_valid = 1'b0;
   endtask

   // Drains all eight currents against exp_cur; optionally stalls 5 cycles at one channel
   task automatic collect(input int stall_ch, input logic [7:0] stall_frame);
      int n;
      for (int i = 0; i < 8; i++) begin
         n = 0;
         cur_ready = 1'b1;
         while (!cur_valid && n < 50) begin
            tick();
            n++;
         end
         chk("cur_timeout", 32'(n < 50), 32'd1);
         chk($sformatf("cur_ch[%0d]", i), 32'(cur_ch), 32'(i));
         chk($sformatf("cur_out[%0d]", i), 32'(cur_out), 32'(exp_cur[i]));
         if (i == stall_ch) begin
            cur_ready   = 1'b0;
            spike_in    = stall_frame;
            spike_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
               tick();
               chk("stall_cur_out", 32'(cur_out), 32'(exp_cur[i]));
               chk("stall_cur_ch", 32'(cur_ch), 32'(i));
               chk("stall_cur_valid", 32'(cur_valid), 32'd1);
               chk("stall_spike_ready", 32'(spike_ready), 32'd0);
            end
            cur_ready = 1'b1;
         end
         tick();
      end
      cur_ready = 1'b0;
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      spike_in    = '0;
      spike_valid = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      cur_ready   = 1'b0;
      fill(8'd0);

      tick();
      tick();
      chk("rst_spike_ready", 32'(spike_ready), 32'd0);
      chk("rst_cur_valid", 32'(cur_valid), 32'd0);
      chk("rst_cur_out", 32'(cur_out), 32'd0);
      chk("rst_cur_ch", 32'(cur_ch), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_spike_ready", 32'(spike_ready), 32'd1);

      // Full frame on default weights, with first-current latency
      handshake(8'hFF);
      chk("busy_spike_ready", 32'(spike_ready), 32'd0);
      lat = 1;
      while (!cur_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'd9);
      fill(8'd32);
      collect(-1, 8'h00);
      chk("back_idle_spike_ready", 32'(spike_ready), 32'd1);

      // 32 - 16 + 32
      handshake(8'hFF);
      fill(8'd48);
      collect(-1, 8'h00);

      // 48 - 24 + 32, stalled at ch2 with a pending all-zero frame
      handshake(8'hFF);
      fill(8'd56);
      collect(2, 8'h00);
      chk("pending_spike_ready", 32'(spike_ready), 32'd1);
      tick();
      spike_valid = 1'b0;
      chk("pending_accepted", 32'(spike_ready), 32'd0);
      fill(8'd28);
      collect(-1, 8'h00);

      // High saturation on ch3
      do_reset();
      write_w(3'd3, 8'd255);
      handshake(8'h08);
      fill(8'd0);
      exp_cur[3] = 8'd255;
      collect(-1, 8'h00);
      handshake(8'h08);
      collect(-1, 8'h00);

      // Weight write on the edge that sweeps ch4
      do_reset();
      handshake(8'h10);
      repeat (4) tick();
      wr_en   = 1'b1;
      wr_addr = 3'd4;
      wr_data = 8'd100;
      tick();
      wr_en   = 1'b0;
      fill(8'd0);
      exp_cur[4] = 8'd32;
      collect(-1, 8'h00);
      handshake(8'h10);
      exp_cur[4] = 8'd116;
      collect(-1, 8'h00);

      // Reset on the edge that sweeps ch5
      handshake(8'hFF);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("midsweep_rst_cur_valid", 32'(cur_valid), 32'd0);
      chk("midsweep_rst_spike_ready", 32'(spike_ready), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_spike_ready", 32'(spike_ready), 32'd1);
      handshake(8'h11);
      fill(8'd0);
      exp_cur[0] = 8'd32;
      exp_cur[4] = 8'd32;
      collect(-1, 8'h00);

      // Write during reset is dropped; then a large/negative weight on ch1
      rst     = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 3'd1;
      wr_data = 8'd7;
      tick();
      rst   = 1'b0;
      wr_en = 1'b0;
      tick();
      handshake(8'h02);
      fill(8'd0);
      exp_cur[1] = 8'd32;
      collect(-1, 8'h00);
      write_w(3'd1, 8'hD8);
      handshake(8'h02);
`ifdef TM_SYN_INHIBIT_EN
      exp_cur[1] = 8'd0;
`else
      exp_cur[1] = 8'd232;
`endif
      collect(-1, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
